// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter that shares the GPIO control IP register port between the host bridge (m0) and the pattern sequencer (m1).
// Optional GPIO_ARB_LOCK_EN adds m0_lock/m1_lock, which keep the grant with a requester across back-to-back transactions.
module gpio_bus_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
`ifdef GPIO_ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  output logic [ADDR_W-1:0] addr_o,
  output logic              write_en_o,
  output logic              read_en_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt;
  logic                last_grant_r;
  logic                last_grant_nxt;
  logic                id_r;
  logic                id_nxt;
  logic                we_r;
  logic                we_nxt;
  logic                winner_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic [DATA_W-1:0]   capture_s;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic                write_en_nxt;
  logic                read_en_nxt;
  logic                m0_ack_nxt;
  logic                m1_ack_nxt;
  logic [DATA_W-1:0]   m0_rdata_nxt;
  logic [DATA_W-1:0]   m1_rdata_nxt;
  logic                busy_nxt;
`ifdef GPIO_ARB_LOCK_EN
  logic                lock_r;
  logic                lock_nxt;
  logic                sel_lock_s;
`endif

  // Winner selection: a lone requester always wins; contention goes to the requester that was not served last.
  always_comb begin
    winner_s = 1'b0;
    if (m0_req && m1_req) begin
`ifdef GPIO_ARB_LOCK_EN
      if (lock_r) begin
        winner_s = last_grant_r;
      end else begin
        winner_s = ~last_grant_r;
      end
`else
      winner_s = ~last_grant_r;
`endif
    end else if (m1_req) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end

  // Command multiplexer feeding the latch taken in IDLE.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = {ADDR_W{1'b0}};
    sel_wdata_s = {DATA_W{1'b0}};
`ifdef GPIO_ARB_LOCK_EN
    sel_lock_s  = 1'b0;
`endif
    if (winner_s) begin
      sel_we_s    = m1_we;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
`ifdef GPIO_ARB_LOCK_EN
      sel_lock_s  = m1_lock;
`endif
    end else begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
`ifdef GPIO_ARB_LOCK_EN
      sel_lock_s  = m0_lock;
`endif
    end
  end

  // Writes return zero data; reads take the IP's combinational rdata at the edge that ends ISSUE.
  always_comb begin
    if (we_r) begin
      capture_s = {DATA_W{1'b0}};
    end else begin
      capture_s = rdata_i;
    end
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_nxt      = state_r;
    last_grant_nxt = last_grant_r;
    id_nxt         = id_r;
    we_nxt         = we_r;
    addr_nxt       = {ADDR_W{1'b0}};
    wdata_nxt      = {DATA_W{1'b0}};
    write_en_nxt   = 1'b0;
    read_en_nxt    = 1'b0;
    m0_ack_nxt     = 1'b0;
    m1_ack_nxt     = 1'b0;
    m0_rdata_nxt   = {DATA_W{1'b0}};
    m1_rdata_nxt   = {DATA_W{1'b0}};
    busy_nxt       = 1'b0;
`ifdef GPIO_ARB_LOCK_EN
    lock_nxt       = lock_r;
`endif
    case (state_r)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_nxt    = ISSUE;
          id_nxt       = winner_s;
          we_nxt       = sel_we_s;
          addr_nxt     = sel_addr_s;
          wdata_nxt    = sel_wdata_s;
          write_en_nxt = sel_we_s;
          read_en_nxt  = ~sel_we_s;
          busy_nxt     = 1'b1;
`ifdef GPIO_ARB_LOCK_EN
          lock_nxt     = sel_lock_s;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        state_nxt  = RESP;
        busy_nxt   = 1'b1;
        m0_ack_nxt = ~id_r;
        m1_ack_nxt = id_r;
        if (id_r) begin
          m1_rdata_nxt = capture_s;
        end else begin
          m0_rdata_nxt = capture_s;
        end
      end
      RESP: begin
        state_nxt      = IDLE;
        last_grant_nxt = id_r;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, command latch and registered outputs; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      id_r         <= 1'b0;
      we_r         <= 1'b0;
      addr_o       <= {ADDR_W{1'b0}};
      wdata_o      <= {DATA_W{1'b0}};
      write_en_o   <= 1'b0;
      read_en_o    <= 1'b0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_rdata     <= {DATA_W{1'b0}};
      m1_rdata     <= {DATA_W{1'b0}};
      busy_o       <= 1'b0;
`ifdef GPIO_ARB_LOCK_EN
      lock_r       <= 1'b0;
`endif
    end else begin
      state_r      <= state_nxt;
      last_grant_r <= last_grant_nxt;
      id_r         <= id_nxt;
      we_r         <= we_nxt;
      addr_o       <= addr_nxt;
      wdata_o      <= wdata_nxt;
      write_en_o   <= write_en_nxt;
      read_en_o    <= read_en_nxt;
      m0_ack       <= m0_ack_nxt;
      m1_ack       <= m1_ack_nxt;
      m0_rdata     <= m0_rdata_nxt;
      m1_rdata     <= m1_rdata_nxt;
      busy_o       <= busy_nxt;
`ifdef GPIO_ARB_LOCK_EN
      lock_r       <= lock_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter with a small GPIO register model (data 0x0, dir 0x4, pin 0x8 read-only).
module tb_gpio_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m0_ack;
  logic [3:0]  m0_addr;
  logic [31:0] m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_ack;
  logic [3:0]  m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic        m0_lock, m1_lock;
  logic [3:0]  addr_o;
  logic        write_en_o, read_en_o, busy_o;
  logic [31:0] wdata_o, rdata_i;

  int total;
  int bad;

  logic [31:0] gpio_data, gpio_dir;

  logic        iss_wen, iss_ren, iss_busy, rsp_wen, rsp_ren;
  logic [3:0]  iss_addr;
  logic [31:0] iss_wdata, iss_rd0, rsp_rd0, rsp_rd1;
  logic [1:0]  iss_ack, rsp_ack;

  gpio_bus_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
`ifdef GPIO_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .addr_o(addr_o), .write_en_o(write_en_o), .read_en_o(read_en_o),
    .wdata_o(wdata_o), .rdata_i(rdata_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GPIO IP stand-in: combinational read, write on the strobe edge, pin = data & dir.
  always_comb begin
    case (addr_o[3:2])
      2'd0:    rdata_i = gpio_data;
      2'd1:    rdata_i = gpio_dir;
      2'd2:    rdata_i = gpio_data & gpio_dir;
      default: rdata_i = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (write_en_o && addr_o[3:2] == 2'd0) gpio_data <= wdata_o;
    if (write_en_o && addr_o[3:2] == 2'd1) gpio_dir <= wdata_o;
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one transaction from an IDLE negedge and records the ISSUE and RESP cycles.
  task automatic txn(input bit m, input bit we, input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    if (m) begin
      m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
    end
    @(negedge clk);
    iss_wen = write_en_o; iss_ren = read_en_o; iss_addr = addr_o; iss_wdata = wdata_o;
    iss_ack = {m1_ack, m0_ack}; iss_busy = busy_o; iss_rd0 = m0_rdata;
    @(negedge clk);
    rsp_wen = write_en_o; rsp_ren = read_en_o; rsp_ack = {m1_ack, m0_ack};
    rsp_rd0 = m0_rdata; rsp_rd1 = m1_rdata;
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 4'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 4'h0; m1_wdata = 32'h0;
    m0_lock = 1'b0; m1_lock = 1'b0;
    gpio_data = 32'h0; gpio_dir = 32'h0;
    @(negedge clk);
    m0_req = 1'b1; m1_req = 1'b1;
    @(negedge clk);
    total++; if ({write_en_o, read_en_o, busy_o} !== 3'b000) begin bad++; $display("FAIL reset_strobes: got %b want 000", {write_en_o, read_en_o, busy_o}); end
    total++; if ({m0_ack, m1_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks: got %b want 00", {m0_ack, m1_ack}); end
    total++; if ({addr_o, wdata_o, m0_rdata, m1_rdata} !== 100'h0) begin bad++; $display("FAIL reset_data: got %h %h %h %h want 0", addr_o, wdata_o, m0_rdata, m1_rdata); end
    m0_req = 1'b0; m1_req = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_contention();
    int n_ack;
    int n_iss;
    int ack_cyc[4];
    logic ack_who[4];
    logic [3:0] iss_a[4];
    int both_ack;
    int exp_cyc[4] = '{2, 5, 8, 11};
    logic exp_who[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp_a[4] = '{4'h0, 4'h4, 4'h0, 4'h4};
    n_ack = 0; n_iss = 0; both_ack = 0;
    apply_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 4'h0; m0_wdata = 32'h11;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 4'h4; m1_wdata = 32'h22;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (m0_ack && m1_ack) both_ack++;
      if ((m0_ack || m1_ack) && n_ack < 4) begin ack_cyc[n_ack] = c; ack_who[n_ack] = m1_ack; n_ack++; end
      if (write_en_o && n_iss < 4) begin iss_a[n_iss] = addr_o; n_iss++; end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    total++; if (n_ack !== 4) begin bad++; $display("FAIL rr_ack_count: got %0d want 4", n_ack); end
    total++; if (both_ack !== 0) begin bad++; $display("FAIL rr_double_ack: got %0d want 0", both_ack); end
    for (int i = 0; i < 4; i++) begin
      total++; if (ack_cyc[i] !== exp_cyc[i]) begin bad++; $display("FAIL rr_ack_cycle[%0d]: got %0d want %0d", i, ack_cyc[i], exp_cyc[i]); end
      total++; if (ack_who[i] !== exp_who[i]) begin bad++; $display("FAIL rr_grant[%0d]: got m%0d want m%0d", i, ack_who[i], exp_who[i]); end
      total++; if (iss_a[i] !== exp_a[i]) begin bad++; $display("FAIL rr_issue_addr[%0d]: got %h want %h", i, iss_a[i], exp_a[i]); end
    end
  endtask

  task automatic test_single_write();
    txn(1'b0, 1'b1, 4'h0, 32'h5A);
    total++; if ({iss_wen, iss_ren} !== 2'b10) begin bad++; $display("FAIL wr_strobe: got %b want 10", {iss_wen, iss_ren}); end
    total++; if (iss_addr !== 4'h0 || iss_wdata !== 32'h5A) begin bad++; $display("FAIL wr_cmd: got %h/%h want 0/5a", iss_addr, iss_wdata); end
    total++; if (iss_ack !== 2'b00 || iss_busy !== 1'b1) begin bad++; $display("FAIL wr_issue_ack_busy: got %b/%b want 00/1", iss_ack, iss_busy); end
    total++; if ({rsp_wen, rsp_ren} !== 2'b00) begin bad++; $display("FAIL wr_one_cycle: got %b want 00", {rsp_wen, rsp_ren}); end
    total++; if (rsp_ack !== 2'b01) begin bad++; $display("FAIL wr_ack: got %b want 01", rsp_ack); end
    total++; if (rsp_rd0 !== 32'h0) begin bad++; $display("FAIL wr_rdata_zero: got %h want 0", rsp_rd0); end
    @(negedge clk);
    total++; if ({m0_ack, busy_o} !== 2'b00) begin bad++; $display("FAIL wr_after_ack: got %b want 00", {m0_ack, busy_o}); end
    txn(1'b0, 1'b0, 4'h0, 32'h0);
    total++; if ({iss_wen, iss_ren} !== 2'b01) begin bad++; $display("FAIL rd_strobe: got %b want 01", {iss_wen, iss_ren}); end
    total++; if (iss_rd0 !== 32'h0) begin bad++; $display("FAIL rd_early_rdata: got %h want 0", iss_rd0); end
    total++; if (rsp_ack !== 2'b01 || rsp_rd0 !== 32'h5A) begin bad++; $display("FAIL wr_readback: got %b/%h want 01/5a", rsp_ack, rsp_rd0); end
  endtask

  task automatic test_single_read();
    txn(1'b0, 1'b1, 4'h4, 32'h0F);
    txn(1'b1, 1'b0, 4'h4, 32'h0);
    total++; if ({iss_wen, iss_ren} !== 2'b01 || iss_addr !== 4'h4) begin bad++; $display("FAIL m1_rd_strobe: got %b/%h want 01/4", {iss_wen, iss_ren}, iss_addr); end
    total++; if (rsp_ren !== 1'b0) begin bad++; $display("FAIL m1_rd_one_cycle: got %b want 0", rsp_ren); end
    total++; if (rsp_ack !== 2'b10) begin bad++; $display("FAIL m1_rd_ack: got %b want 10", rsp_ack); end
    total++; if (rsp_rd1 !== 32'h0000000F || rsp_rd0 !== 32'h0) begin bad++; $display("FAIL m1_rd_data: got %h/%h want 0000000f/0", rsp_rd1, rsp_rd0); end
  endtask

  task automatic test_write_read_pin();
    txn(1'b1, 1'b1, 4'h4, 32'hFF);
    txn(1'b1, 1'b1, 4'h0, 32'hA5);
    txn(1'b1, 1'b0, 4'h8, 32'h0);
    total++; if (rsp_ack !== 2'b10 || rsp_rd1 !== 32'hA5) begin bad++; $display("FAIL pin_read: got %b/%h want 10/a5", rsp_ack, rsp_rd1); end
  endtask

  task automatic test_unmapped();
    txn(1'b0, 1'b1, 4'hC, 32'hDEAD);
    total++; if ({iss_wen, rsp_wen} !== 2'b10 || iss_addr !== 4'hC) begin bad++; $display("FAIL unmapped_write: got %b/%h want 10/c", {iss_wen, rsp_wen}, iss_addr); end
    total++; if (rsp_ack !== 2'b01) begin bad++; $display("FAIL unmapped_ack: got %b want 01", rsp_ack); end
    txn(1'b0, 1'b1, 4'h8, 32'h12);
    total++; if ({iss_wen, rsp_wen, rsp_ack} !== 4'b1001) begin bad++; $display("FAIL ro_write: got %b want 1001", {iss_wen, rsp_wen, rsp_ack}); end
    txn(1'b0, 1'b0, 4'h8, 32'h0);
    total++; if (rsp_rd0 !== 32'hA5) begin bad++; $display("FAIL ro_unchanged: got %h want a5", rsp_rd0); end
  endtask

  task automatic test_mid_reset();
    txn(1'b0, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 4'h4;
    @(negedge clk);
    total++; if (read_en_o !== 1'b1) begin bad++; $display("FAIL mr_in_issue: got %b want 1", read_en_o); end
    rst_n = 1'b0;
    #1;
    total++; if ({addr_o, wdata_o, write_en_o, read_en_o, busy_o, m0_ack, m1_ack, m0_rdata, m1_rdata} !== 105'h0) begin bad++; $display("FAIL mr_outputs: got %h/%b/%b want all 0", addr_o, read_en_o, busy_o); end
    @(negedge clk);
    total++; if ({m0_ack, m1_ack} !== 2'b00) begin bad++; $display("FAIL mr_no_ack: got %b want 00", {m0_ack, m1_ack}); end
    rst_n = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 4'h0;
    @(negedge clk);
    total++; if (read_en_o !== 1'b1 || addr_o !== 4'h0) begin bad++; $display("FAIL mr_regrant: got %b/%h want 1/0", read_en_o, addr_o); end
    @(negedge clk);
    total++; if ({m1_ack, m0_ack} !== 2'b01) begin bad++; $display("FAIL mr_m0_wins: got %b want 01", {m1_ack, m0_ack}); end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

`ifdef GPIO_ARB_LOCK_EN
  task automatic test_lock();
    int n;
    logic [3:0] got[5];
    logic [3:0] exp_a[5] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0};
    n = 0;
    apply_reset();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 4'h0; m0_wdata = 32'h33; m0_lock = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 4'h4; m1_wdata = 32'h44; m1_lock = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (write_en_o && n < 5) begin got[n] = addr_o; n++; end
      if (c == 8) m1_lock = 1'b0;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    total++; if (n !== 5) begin bad++; $display("FAIL lock_count: got %0d want 5", n); end
    for (int i = 0; i < 5; i++) begin
      total++; if (got[i] !== exp_a[i]) begin bad++; $display("FAIL lock_order[%0d]: got %h want %h", i, got[i], exp_a[i]); end
    end
  endtask
`endif

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_contention();
    test_single_write();
    test_single_read();
    test_write_read_pin();
    test_unmapped();
    test_mid_reset();
`ifdef GPIO_ARB_LOCK_EN
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
